musb_dmem_port: RTL and testbench

Data-side memory port for the MEM stage. It converts a MEM-stage load or store into a single bus transaction with a request/ready handshake. It produces the `dmem_request_stall` that the pipeline hazard logic consumes, and it detects misaligned accesses and bus errors. It aligns store data and byte enables, and it extracts and sign- or zero-extends load data.

---
 rtl/musb_dmem_port_pkg.sv | 40 ++++
 rtl/musb_dmem_port_load_align.sv | 40 ++++
 rtl/musb_dmem_port.sv | 191 +++++++++++++++++++
 tb/tb_musb_dmem_port.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/musb_dmem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : musb_dmem_port_pkg
// Description : Shared types for the MEM-stage data port: FSM states and
//               access-size codes, plus size decode and alignment helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package musb_dmem_port_pkg;

    typedef enum logic [1:0] {
        MEM_PORT_IDLE = 2'd0,
        MEM_PORT_WAIT = 2'd1,
        MEM_PORT_DONE = 2'd2
    } port_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_t;

    // Byte has priority over halfword; neither set means word.
    function automatic access_size_t decode_size(input logic byte_access,
                                                 input logic half_access);
        if (byte_access) return SIZE_BYTE;
        if (half_access) return SIZE_HALF;
        return SIZE_WORD;
    endfunction

    function automatic logic is_misaligned(input access_size_t size,
                                           input logic [1:0]   lane);
        case (size)
            SIZE_HALF: return lane[0];
            SIZE_WORD: return |lane;
            default:   return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/musb_dmem_port_load_align.sv
`default_nettype none
// ============================================================================
// Module      : musb_dmem_port_load_align
// Description : Selects the addressed byte/halfword lane of a captured bus
//               word and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module musb_dmem_port_load_align
    import musb_dmem_port_pkg::*;
(
    input  logic [31:0]  rdata,
    input  logic [1:0]   lane,
    input  access_size_t size,
    input  logic         sign_extend,
    output logic [31:0]  data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (lane)
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        w_half = lane[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            SIZE_BYTE: data = {{24{sign_extend & w_byte[7]}}, w_byte};
            SIZE_HALF: data = {{16{sign_extend & w_half[15]}}, w_half};
            default:   data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/musb_dmem_port.sv
`default_nettype none
// ============================================================================
// Module      : musb_dmem_port
// Description : MEM-stage data port: turns a load/store into one bus
//               request/ready transaction, raising stall, alignment and bus
//               error indications.
// Revision    : 1.0 - initial release
// ============================================================================
module musb_dmem_port
    import musb_dmem_port_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic        mem_halfword,
    input  logic        mem_sign_extend,
    input  logic        mem_flush,
    input  logic        mem_exception_stall,
    output logic [31:0] mem_load_data,
    output logic        dmem_request_stall,
    output logic        exc_address_l_mem,
    output logic        exc_address_s_mem,
    output logic        exc_bus_error_mem,
    output logic [31:0] dport_address,
    output logic [31:0] dport_data_o,
    output logic [3:0]  dport_wr,
    output logic        dport_enable,
    input  logic [31:0] dport_data_i,
    input  logic        dport_ready,
    input  logic        dport_error
);

    port_state_t  r_state;
    port_state_t  w_state_next;
    logic [31:0]  r_addr;
    logic [1:0]   r_lane;
    logic [31:0]  r_wdata;
    logic [3:0]   r_wr;
    logic [31:0]  r_rdata;
    access_size_t r_size;
    logic         r_sign;
    logic [15:0]  r_count;
    logic         r_error;
    logic         r_killed;

    access_size_t w_size;
    logic         w_misaligned;
    logic         w_valid_req;
    logic [3:0]   w_wr;
    logic [31:0]  w_wdata;
    logic [16:0]  w_count_inc;
    logic         w_timeout;
    logic         w_bus_fail;
    logic         w_bus_done;
    logic         w_killed;
    logic [31:0]  w_align_data;

    assign w_size       = decode_size(mem_byte, mem_halfword);
    assign w_misaligned = is_misaligned(w_size, mem_address[1:0]);
    assign w_valid_req  = (mem_read | mem_write) & ~w_misaligned & ~mem_flush;

    // A simultaneous read+write is a write, so it reports a store fault.
    assign exc_address_s_mem = mem_write & w_misaligned & ~mem_flush;
    assign exc_address_l_mem = mem_read & ~mem_write & w_misaligned & ~mem_flush;

    always_comb begin
        w_wr    = 4'b1111;
        w_wdata = mem_store_data;
        case (w_size)
            SIZE_BYTE: begin
                w_wr    = 4'b0001 << mem_address[1:0];
                w_wdata = {4{mem_store_data[7:0]}};
            end
            SIZE_HALF: begin
                w_wr    = 4'b0011 << mem_address[1:0];
                w_wdata = {2{mem_store_data[15:0]}};
            end
            default: begin
                w_wr    = 4'b1111;
                w_wdata = mem_store_data;
            end
        endcase
        if (!mem_write) begin
            w_wr = 4'b0000;
        end
    end

    // Timeout fires in the TIMEOUT_CYCLES-th WAIT cycle; an error condition
    // outranks a ready arriving in the same cycle.
    assign w_count_inc = {1'b0, r_count} + 17'd1;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (w_count_inc == 17'(TIMEOUT_CYCLES));
    assign w_bus_fail  = dport_error | w_timeout;
    assign w_bus_done  = dport_ready | w_bus_fail;
    assign w_killed    = r_killed | mem_flush;

    always_comb begin
        w_state_next       = r_state;
        dmem_request_stall = 1'b0;
        dport_enable       = 1'b0;
        case (r_state)
            MEM_PORT_IDLE: begin
                dmem_request_stall = w_valid_req;
                if (w_valid_req) begin
                    w_state_next = MEM_PORT_WAIT;
                end
            end
            MEM_PORT_WAIT: begin
                dmem_request_stall = 1'b1;
                dport_enable       = 1'b1;
                if (w_bus_done) begin
                    w_state_next = w_killed ? MEM_PORT_IDLE : MEM_PORT_DONE;
                end
            end
            MEM_PORT_DONE: begin
                if (!mem_exception_stall) begin
                    w_state_next = MEM_PORT_IDLE;
                end
            end
            default: w_state_next = MEM_PORT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MEM_PORT_IDLE;
            r_addr   <= 32'd0;
            r_lane   <= 2'd0;
            r_wdata  <= 32'd0;
            r_wr     <= 4'd0;
            r_rdata  <= 32'd0;
            r_size   <= SIZE_BYTE;
            r_sign   <= 1'b0;
            r_count  <= 16'd0;
            r_error  <= 1'b0;
            r_killed <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                MEM_PORT_IDLE: begin
                    if (w_valid_req) begin
                        r_addr   <= {mem_address[31:2], 2'b00};
                        r_lane   <= mem_address[1:0];
                        r_wdata  <= w_wdata;
                        r_wr     <= w_wr;
                        r_size   <= w_size;
                        r_sign   <= mem_sign_extend;
                        r_count  <= 16'd0;
                        r_error  <= 1'b0;
                        r_killed <= 1'b0;
                    end
                end
                MEM_PORT_WAIT: begin
                    r_count <= w_count_inc[15:0];
                    if (mem_flush) begin
                        r_killed <= 1'b1;
                    end
                    if (w_bus_done && !w_killed) begin
                        if (w_bus_fail) begin
                            r_error <= 1'b1;
                        end else begin
                            r_rdata <= dport_data_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    musb_dmem_port_load_align u_load_align (
        .rdata       (r_rdata),
        .lane        (r_lane),
        .size        (r_size),
        .sign_extend (r_sign),
        .data        (w_align_data)
    );

    assign mem_load_data     = (r_state == MEM_PORT_DONE && !r_error) ? w_align_data : 32'd0;
    assign exc_bus_error_mem = (r_state == MEM_PORT_DONE) & r_error;
    assign dport_address     = r_addr;
    assign dport_data_o      = r_wdata;
    assign dport_wr          = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_musb_dmem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_musb_dmem_port
// Description : Self-checking bench for musb_dmem_port: transaction-level
//               expected outputs compared every cycle, plus literal pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_musb_dmem_port;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_address, mem_store_data;
    logic        mem_read, mem_write, mem_byte, mem_halfword, mem_sign_extend;
    logic        mem_flush, mem_exception_stall;
    logic [31:0] mem_load_data;
    logic        dmem_request_stall, exc_address_l_mem, exc_address_s_mem, exc_bus_error_mem;
    logic [31:0] dport_address, dport_data_o, dport_data_i;
    logic [3:0]  dport_wr;
    logic        dport_enable, dport_ready, dport_error;

    always #5 clk = ~clk;

    musb_dmem_port #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_address         (mem_address),
        .mem_store_data      (mem_store_data),
        .mem_read            (mem_read),
        .mem_write           (mem_write),
        .mem_byte            (mem_byte),
        .mem_halfword        (mem_halfword),
        .mem_sign_extend     (mem_sign_extend),
        .mem_flush           (mem_flush),
        .mem_exception_stall (mem_exception_stall),
        .mem_load_data       (mem_load_data),
        .dmem_request_stall  (dmem_request_stall),
        .exc_address_l_mem   (exc_address_l_mem),
        .exc_address_s_mem   (exc_address_s_mem),
        .exc_bus_error_mem   (exc_bus_error_mem),
        .dport_address       (dport_address),
        .dport_data_o        (dport_data_o),
        .dport_wr            (dport_wr),
        .dport_enable        (dport_enable),
        .dport_data_i        (dport_data_i),
        .dport_ready         (dport_ready),
        .dport_error         (dport_error)
    );

    int total = 0;
    int bad   = 0;

    // Expected outputs for the current cycle, published by the driver.
    logic        e_on = 1'b0;
    logic [31:0] e_load, e_addr, e_dout;
    logic [3:0]  e_wr;
    logic        e_stall, e_exl, e_exs, e_berr, e_en, e_done;
    // Model of the bus-side registered outputs (last issued request).
    logic [31:0] m_addr = 32'd0, m_dout = 32'd0;
    logic [3:0]  m_wr = 4'd0;

    // Observations used by the literal checks.
    int          stall_run = 0, en_run = 0, txn = 0;
    logic        prev_en = 1'b0, exl_seen = 1'b0;
    logic [31:0] last_load = 32'd0, obs_addr = 32'd0, obs_dout = 32'd0;
    logic [3:0]  obs_wr = 4'd0;
    logic        last_berr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (e_on) begin
            chk("mem_load_data",  mem_load_data, e_load);
            chk("stall",          {31'd0, dmem_request_stall}, {31'd0, e_stall});
            chk("exc_l",          {31'd0, exc_address_l_mem},  {31'd0, e_exl});
            chk("exc_s",          {31'd0, exc_address_s_mem},  {31'd0, e_exs});
            chk("bus_err",        {31'd0, exc_bus_error_mem},  {31'd0, e_berr});
            chk("dport_enable",   {31'd0, dport_enable},       {31'd0, e_en});
            chk("dport_address",  dport_address, e_addr);
            chk("dport_data_o",   dport_data_o,  e_dout);
            chk("dport_wr",       {28'd0, dport_wr}, {28'd0, e_wr});
        end
        if (dmem_request_stall) stall_run++;
        if (dport_enable) begin
            en_run++;
            obs_addr = dport_address;
            obs_dout = dport_data_o;
            obs_wr   = dport_wr;
        end
        if (dport_enable && !prev_en) txn++;
        prev_en = dport_enable;
        if (exc_address_l_mem) exl_seen = 1'b1;
        if (e_done) begin
            last_load = mem_load_data;
            last_berr = exc_bus_error_mem;
        end
    end

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                               input int size, input bit sgn);
        logic [31:0] sh;
        sh = w >> (8 * a);
        if (size == 0) return (sgn && sh[7])  ? ((sh & 32'hFF)   | 32'hFFFFFF00) : (sh & 32'hFF);
        if (size == 1) return (sgn && sh[15]) ? ((sh & 32'hFFFF) | 32'hFFFF0000) : (sh & 32'hFFFF);
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        e_load = 32'd0; e_stall = 1'b0; e_exl = 1'b0; e_exs = 1'b0;
        e_berr = 1'b0;  e_en = 1'b0;    e_done = 1'b0;
        e_addr = m_addr; e_dout = m_dout; e_wr = m_wr;
    endtask

    task automatic clear_inputs();
        mem_read = 1'b0; mem_write = 1'b0; mem_byte = 1'b0; mem_halfword = 1'b0;
        mem_sign_extend = 1'b0; mem_flush = 1'b0; mem_exception_stall = 1'b0;
    endtask

    // One MEM-stage access: IDLE issue, lat-cycle bus response (0 = none),
    // optional flush from WAIT cycle flush_at, exc_cyc held DONE cycles.
    task automatic do_access(input bit rd, input bit wr, input int size, input bit sgn,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int lat, input bit is_err,
                             input bit flush_idle, input int flush_at, input int exc_cyc);
        bit mis, resp_in, timed, err, killed;
        int end_w;
        mem_read = rd; mem_write = wr; mem_byte = (size == 0); mem_halfword = (size == 1);
        mem_sign_extend = sgn; mem_address = addr; mem_store_data = sdata;
        mem_flush = flush_idle;
        mis = (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);
        set_idle_exp();
        if (!(rd || wr) || mis || flush_idle) begin
            e_exs = wr && mis && !flush_idle;
            e_exl = rd && !wr && mis && !flush_idle;
            cyc();
            clear_inputs();
            set_idle_exp();
            return;
        end
        e_stall = 1'b1;
        cyc();
        m_addr = {addr[31:2], 2'b00};
        case (size)
            0:       begin m_wr = 4'b0001 << addr[1:0]; m_dout = {4{sdata[7:0]}};  end
            1:       begin m_wr = 4'b0011 << addr[1:0]; m_dout = {2{sdata[15:0]}}; end
            default: begin m_wr = 4'b1111;              m_dout = sdata;            end
        endcase
        if (!wr) m_wr = 4'b0000;
        resp_in = (lat != 0) && (TO == 0 || lat <= TO);
        end_w   = resp_in ? lat : TO;
        timed   = (TO != 0) && (end_w == TO);
        err     = (resp_in && is_err) || timed;
        killed  = (flush_at != 0) && (flush_at <= end_w);
        for (int w = 1; w <= end_w; w++) begin
            mem_flush    = (flush_at != 0) && (w >= flush_at);
            dport_ready  = (w == lat) && !is_err;
            dport_error  = (w == lat) && is_err;
            dport_data_i = (w == lat) ? rdata : $urandom;
            set_idle_exp();
            e_stall = 1'b1;
            e_en    = 1'b1;
            cyc();
        end
        dport_ready  = 1'b0;
        dport_error  = 1'b0;
        dport_data_i = $urandom;
        if (killed) begin
            clear_inputs();
            set_idle_exp();
            return;
        end
        mem_flush = 1'b0;
        for (int k = 0; k <= exc_cyc; k++) begin
            mem_exception_stall = (k < exc_cyc);
            set_idle_exp();
            e_done = 1'b1;
            e_berr = err;
            e_load = err ? 32'd0 : model_load(rdata, addr[1:0], size, sgn);
            cyc();
        end
        clear_inputs();
        set_idle_exp();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        mem_address = 32'd0; mem_store_data = 32'd0;
        dport_data_i = 32'd0; dport_ready = 1'b0; dport_error = 1'b0;
        set_idle_exp();
        cyc();
        e_on = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Zero-wait word load.
        stall_run = 0; en_run = 0;
        do_access(1, 0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
        chk("lit_word_stall", stall_run, 2);
        chk("lit_word_load", last_load, 32'hDEADBEEF);
        chk("lit_word_wr", {28'd0, obs_wr}, 32'd0);

        do_access(1, 0, 0, 1, 32'h103, 32'h0, 32'h80112233, 1, 0, 0, 0, 0);
        chk("lit_byte_signed", last_load, 32'hFFFFFF80);
        do_access(1, 0, 0, 0, 32'h103, 32'h0, 32'h80112233, 2, 0, 0, 0, 0);
        chk("lit_byte_unsigned", last_load, 32'h00000080);

        en_run = 0;
        do_access(0, 1, 1, 0, 32'h102, 32'h0000ABCD, 32'h0, 3, 0, 0, 0, 0);
        chk("lit_half_wait", en_run, 3);
        chk("lit_half_wr", {28'd0, obs_wr}, 32'h0000000C);
        chk("lit_half_data", obs_dout, 32'hABCDABCD);
        chk("lit_half_addr", obs_addr, 32'h00000100);

        en_run = 0; stall_run = 0; exl_seen = 1'b0;
        do_access(1, 0, 2, 0, 32'h101, 32'h0, 32'h0, 1, 0, 0, 0, 0);
        cyc();
        chk("lit_mis_enable", en_run, 0);
        chk("lit_mis_stall", stall_run, 0);
        chk("lit_mis_exc", {31'd0, exl_seen}, 32'd1);
        exl_seen = 1'b0;
        do_access(1, 0, 2, 0, 32'h101, 32'h0, 32'h0, 1, 0, 1, 0, 0);
        chk("lit_mis_flush_exc", {31'd0, exl_seen}, 32'd0);

        do_access(1, 0, 2, 0, 32'h200, 32'h0, 32'h12345678, 2, 1, 0, 0, 0);
        chk("lit_err_flag", {31'd0, last_berr}, 32'd1);
        chk("lit_err_load", last_load, 32'd0);
        en_run = 0;
        do_access(1, 0, 2, 0, 32'h204, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        chk("lit_timeout_wait", en_run, 4);
        chk("lit_timeout_flag", {31'd0, last_berr}, 32'd1);

        txn = 0;
        do_access(1, 0, 2, 0, 32'h300, 32'h0, 32'hCAFEF00D, 1, 0, 0, 0, 3);
        chk("lit_excstall_txn", txn, 1);
        chk("lit_excstall_load", last_load, 32'hCAFEF00D);

        stall_run = 0; en_run = 0;
        do_access(1, 0, 2, 0, 32'h400, 32'h0, 32'h55AA55AA, 4, 0, 0, 2, 0);
        cyc();
        chk("lit_killed_stall", stall_run, 5);
        chk("lit_killed_wait", en_run, 4);

        // Reset while a request is outstanding.
        mem_read = 1'b1; mem_address = 32'h500; mem_store_data = 32'h13572468;
        set_idle_exp(); e_stall = 1'b1;
        cyc();
        m_addr = 32'h500; m_dout = 32'h13572468; m_wr = 4'd0;
        set_idle_exp(); e_stall = 1'b1; e_en = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        clear_inputs();
        m_addr = 32'd0; m_dout = 32'd0; m_wr = 4'd0;
        set_idle_exp();
        cyc();
        rst = 1'b0;
        cyc();

        for (int n = 0; n < 200; n++) begin
            bit          rd, wr, sgn, ferr, fidle;
            int          size, lat, fat, exc;
            logic [31:0] addr;
            rd    = ($urandom_range(0, 9) < 6);
            wr    = ($urandom_range(0, 9) < 4);
            sgn   = $urandom_range(0, 1) == 1;
            size  = $urandom_range(0, 2);
            addr  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                addr[1:0] = (size == 2) ? 2'b00 : (size == 1) ? {addr[1], 1'b0} : addr[1:0];
            end
            lat   = $urandom_range(0, 6);
            ferr  = $urandom_range(0, 5) == 0;
            fidle = $urandom_range(0, 9) == 0;
            fat   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
            exc   = $urandom_range(0, 2);
            do_access(rd, wr, size, sgn, addr, $urandom, $urandom, lat, ferr, fidle, fat, exc);
        end

        cyc();
        e_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
